// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI types, widths and constants
package spi_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

    // Master clock-divider encodings, kept here so master users and slave share them.
    localparam logic [1:0] CDIV_4  = 2'b00;
    localparam logic [1:0] CDIV_8  = 2'b01;
    localparam logic [1:0] CDIV_16 = 2'b10;
    localparam logic [1:0] CDIV_32 = 2'b11;

    localparam logic [BYTE_W-1:0] SPI_IDLE_BYTE = 8'hFF;
    localparam logic              SPI_IDLE_BIT  = 1'b1;

endpackage

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI pin and receive/transmit handshake bundle
interface spi_slave_if;
    import spi_pkg::*;

    logic              mlb;
    logic              ss;
    logic              sck;
    logic              sdi;
    logic              sdo;
    logic              sdo_oe;
    logic [BYTE_W-1:0] tdat;
    logic              tx_taken;
    logic [BYTE_W-1:0] rdata;
    logic              rx_valid;
    logic              rx_ready;
    logic              overrun;
    logic              aborted;

    modport slave (
        input  mlb, ss, sck, sdi, tdat, rx_ready,
        output sdo, sdo_oe, tx_taken, rdata, rx_valid, overrun, aborted
    );

    modport master (
        output mlb, ss, sck, sdi, tdat, rx_ready,
        input  sdo, sdo_oe, tx_taken, rdata, rx_valid, overrun, aborted
    );

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - input synchronizer with registered rise/fall strobes
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~prev_q;
        fall_d = ~sync_q[STAGES-1] & prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - mode-3 SPI slave, oversampled in the clk domain
module spi_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstb,
    spi_slave_if.slave  bus
);

    localparam logic [3:0] BITS_FULL = 4'(BYTE_W);

    logic sck_level_unused, sck_rise, sck_fall;
    logic ss_level_unused, ss_rise, ss_fall;
    logic sdi_s, sdi_rise_unused, sdi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sck (
        .clk(clk), .rst_n(rstb), .d(bus.sck),
        .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss (
        .clk(clk), .rst_n(rstb), .d(bus.ss),
        .level(ss_level_unused), .rise(ss_rise), .fall(ss_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sdi (
        .clk(clk), .rst_n(rstb), .d(bus.sdi),
        .level(sdi_s), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
    );

    spi_state_t        state_q, state_d;
    logic [3:0]        bitcnt_q, bitcnt_d;
    logic [BYTE_W-1:0] rreg_q, rreg_d;
    logic [BYTE_W-1:0] treg_q, treg_d;
    logic [BYTE_W-1:0] rdata_q, rdata_d;
    logic              sdo_q, sdo_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_taken_q, tx_taken_d;
    logic              overrun_q, overrun_d;
    logic              aborted_q, aborted_d;
    logic [BYTE_W-1:0] tx_shift;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        rreg_d     = rreg_q;
        treg_d     = treg_q;
        rdata_d    = rdata_q;
        sdo_d      = sdo_q;
        rx_valid_d = rx_valid_q;
        tx_taken_d = 1'b0;
        overrun_d  = 1'b0;
        aborted_d  = 1'b0;
        tx_shift   = bus.mlb ? {treg_q[BYTE_W-2:0], 1'b1} : {1'b1, treg_q[BYTE_W-1:1]};

        if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                sdo_d    = SPI_IDLE_BIT;
                bitcnt_d = '0;
                if (ss_fall) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A full byte commits one cycle after its 8th rise, even if ss rises meanwhile.
                if (bitcnt_q == BITS_FULL) begin
                    rdata_d    = rreg_q;
                    rx_valid_d = 1'b1;
                    overrun_d  = rx_valid_q && !bus.rx_ready;
                    bitcnt_d   = '0;
                    rreg_d     = SPI_IDLE_BYTE;
                end
                if (ss_rise) begin
                    state_d   = IDLE;
                    sdo_d     = SPI_IDLE_BIT;
                    bitcnt_d  = '0;
                    rreg_d    = SPI_IDLE_BYTE;
                    aborted_d = (bitcnt_q != 4'd0) && (bitcnt_q != BITS_FULL);
                end else if (sck_fall) begin
                    if (bitcnt_q == 4'd0) begin
                        treg_d     = bus.tdat;
                        sdo_d      = bus.mlb ? bus.tdat[BYTE_W-1] : bus.tdat[0];
                        tx_taken_d = 1'b1;
                    end else begin
                        treg_d = tx_shift;
                        sdo_d  = bus.mlb ? tx_shift[BYTE_W-1] : tx_shift[0];
                    end
                end else if (sck_rise) begin
                    rreg_d   = bus.mlb ? {rreg_q[BYTE_W-2:0], sdi_s} : {sdi_s, rreg_q[BYTE_W-1:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                sdo_d    = SPI_IDLE_BIT;
                bitcnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            rreg_q     <= SPI_IDLE_BYTE;
            treg_q     <= SPI_IDLE_BYTE;
            rdata_q    <= SPI_IDLE_BYTE;
            sdo_q      <= SPI_IDLE_BIT;
            rx_valid_q <= 1'b0;
            tx_taken_q <= 1'b0;
            overrun_q  <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            rreg_q     <= rreg_d;
            treg_q     <= treg_d;
            rdata_q    <= rdata_d;
            sdo_q      <= sdo_d;
            rx_valid_q <= rx_valid_d;
            tx_taken_q <= tx_taken_d;
            overrun_q  <= overrun_d;
            aborted_q  <= aborted_d;
        end
    end

    assign bus.sdo      = sdo_q;
    assign bus.sdo_oe   = (state_q == SHIFT);
    assign bus.rdata    = rdata_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_taken = tx_taken_q;
    assign bus.overrun  = overrun_q;
    assign bus.aborted  = aborted_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - scoreboard bench driving spi_slave through a mode-3 master BFM
module tb_spi_slave;
    import spi_pkg::*;

    localparam int HALF = 6;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    spi_slave_if bus ();

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int tx_cnt  = 0;
    int ovr_cnt = 0;
    int abt_cnt = 0;
    logic prev_valid = 1'b0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.tx_taken) tx_cnt++;
        if (bus.overrun)  ovr_cnt++;
        if (bus.aborted)  abt_cnt++;
        if (bus.rx_valid && !prev_valid) begin
            if (exp_rx.size() == 0) check("rx_unexpected", {24'd0, bus.rdata}, 32'h100);
            else                    check("rx_byte", {24'd0, bus.rdata}, {24'd0, exp_rx.pop_front()});
        end
        prev_valid = bus.rx_valid;
    end

    task automatic xfer(input logic [7:0] mo, input logic [7:0] st, input int nbits,
                        input bit lat, output logic [7:0] mi);
        bus.tdat = st;
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.sck = 1'b0;
            bus.sdi = bus.mlb ? mo[7-i] : mo[i];
            repeat (HALF) @(negedge clk);
            mi = bus.mlb ? {mi[6:0], bus.sdo} : {bus.sdo, mi[7:1]};
            bus.sck = 1'b1;
            if (lat && i == 7) begin
                repeat (4) @(negedge clk);
                check("lat_before", {31'd0, bus.rx_valid}, 32'd0);
                @(negedge clk);
                check("lat_at", {31'd0, bus.rx_valid}, 32'd1);
                repeat (HALF - 5) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic byte_xfer(input logic [7:0] mo, input logic [7:0] st, input bit push_rx, input bit lat);
        logic [7:0] mi;
        if (push_rx) exp_rx.push_back(mo);
        exp_tx.push_back(st);
        xfer(mo, st, 8, lat, mi);
        check("master_rx", {24'd0, mi}, {24'd0, exp_tx.pop_front()});
    endtask

    task automatic ss_low();
        @(negedge clk);
        bus.ss = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (2) @(negedge clk);
        bus.ss = 1'b1;
        repeat (HALF + 2) @(negedge clk);
    endtask

    initial begin
        int t0, o0, a0;
        logic [7:0] junk;
        bus.ss = 1'b1; bus.sck = 1'b1; bus.sdi = 1'b1; bus.mlb = 1'b1;
        bus.tdat = 8'h00; bus.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sdo", {31'd0, bus.sdo}, 32'd1);
        check("rst_sdo_oe", {31'd0, bus.sdo_oe}, 32'd0);
        check("rst_rdata", {24'd0, bus.rdata}, 32'hFF);
        check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("rst_tx_taken", {31'd0, bus.tx_taken}, 32'd0);
        rstb = 1'b1;
        repeat (4) @(negedge clk);

        // MSB-first single byte
        bus.mlb = 1'b1; t0 = tx_cnt;
        ss_low();
        byte_xfer(8'hA5, 8'h3C, 1'b1, 1'b1);
        check("sdo_oe_active", {31'd0, bus.sdo_oe}, 32'd1);
        ss_high();
        check("t1_tx_taken", tx_cnt - t0, 32'd1);
        check("t1_sdo_oe_idle", {31'd0, bus.sdo_oe}, 32'd0);
        check("t1_sdo_idle", {31'd0, bus.sdo}, 32'd1);

        // LSB-first single byte
        bus.mlb = 1'b0; t0 = tx_cnt;
        ss_low();
        byte_xfer(8'h81, 8'h7E, 1'b1, 1'b1);
        ss_high();
        check("t2_tx_taken", tx_cnt - t0, 32'd1);

        // two bytes in one frame, tdat changes between bytes
        bus.mlb = 1'b1; t0 = tx_cnt;
        ss_low();
        byte_xfer(8'h12, 8'hF0, 1'b1, 1'b1);
        byte_xfer(8'h34, 8'h0F, 1'b1, 1'b0);
        ss_high();
        check("t3_tx_taken", tx_cnt - t0, 32'd2);

        // overrun with consumer stalled
        bus.rx_ready = 1'b0; o0 = ovr_cnt;
        ss_low();
        byte_xfer(8'h55, 8'h00, 1'b1, 1'b1);
        byte_xfer(8'hAA, 8'h00, 1'b0, 1'b0);
        ss_high();
        check("t4_overrun", ovr_cnt - o0, 32'd1);
        check("t4_rdata", {24'd0, bus.rdata}, 32'hAA);
        check("t4_rx_valid", {31'd0, bus.rx_valid}, 32'd1);

        // abort after 4 bits leaves the pending byte alone
        a0 = abt_cnt;
        ss_low();
        xfer(8'hF0, 8'h00, 4, 1'b0, junk);
        ss_high();
        check("t5_aborted", abt_cnt - a0, 32'd1);
        check("t5_rx_valid_kept", {31'd0, bus.rx_valid}, 32'd1);
        check("t5_rdata_kept", {24'd0, bus.rdata}, 32'hAA);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        check("t5_consume", {31'd0, bus.rx_valid}, 32'd0);
        ss_low();
        byte_xfer(8'hC3, 8'h99, 1'b1, 1'b1);
        ss_high();

        // asynchronous reset mid-byte
        bus.rx_ready = 1'b0;
        ss_low();
        byte_xfer(8'h66, 8'h11, 1'b1, 1'b1);
        ss_high();
        check("t6_pending", {31'd0, bus.rx_valid}, 32'd1);
        a0 = abt_cnt; o0 = ovr_cnt;
        ss_low();
        xfer(8'h5A, 8'h00, 5, 1'b0, junk);
        @(negedge clk);
        rstb = 1'b0;
        #1;
        check("t6_rst_sdo", {31'd0, bus.sdo}, 32'd1);
        check("t6_rst_sdo_oe", {31'd0, bus.sdo_oe}, 32'd0);
        check("t6_rst_rdata", {24'd0, bus.rdata}, 32'hFF);
        check("t6_rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        @(negedge clk);
        bus.ss = 1'b1; bus.sck = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_no_abort", abt_cnt - a0, 32'd0);
        check("t6_no_overrun", ovr_cnt - o0, 32'd0);
        rstb = 1'b1; bus.rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        t0 = tx_cnt;
        ss_low();
        byte_xfer(8'h5A, 8'hC5, 1'b1, 1'b1);
        ss_high();
        check("t6_tx_taken", tx_cnt - t0, 32'd1);

        check("rx_drained", exp_rx.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
